ucsbece154_lsu_dual: RTL and testbench
======================================

Name: ucsbece154_lsu_dual

Overview:
Dual-lane load/store unit: the initiator side of the two-port data memory. It accepts up to two memory requests per cycle from the superscalar pipeline (lane 1 older, lane 2 younger) and validates alignment and range. It drives the memory's two read/write ports and returns registered, in-order responses. When a same-word hazard exists between the two lanes, it serialises them over two cycles so that writes never race and loads see program order.

Parameters:
DATA_START, 32'h10000000, base byte address of data memory
DATA_SIZE, 64, number of 32-bit words in data memory (must match memory instance)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
req1_valid_i / req2_valid_i  in  1  lane request present
req1_we_i / req2_we_i  in  1  1=store, 0=load
req1_addr_i / req2_addr_i  in  32  byte address
req1_wdata_i / req2_wdata_i  in  32  store data
req1_tag_i / req2_tag_i  in  5  destination register tag, echoed in response
req_ready_o  out  1  pair accepted at this edge when high
resp1_valid_o / resp2_valid_o  out  1  response present (loads and stores)
resp1_rdata_o / resp2_rdata_o  out  32  load data; 0 for stores and faults
resp1_tag_o / resp2_tag_o  out  5  echoed tag
resp1_fault_o / resp2_fault_o  out  1  misaligned or out-of-range access
dmem_we_o / dmem_we2_o  out  1  memory port write enables
dmem_a_o / dmem_a2_o  out  32  memory port addresses
dmem_wd_o / dmem_wd2_o  out  32  memory port write data
dmem_rd_i / dmem_rd2_i  in  32  memory port read data (combinational; high-Z when out of range)

Behaviour:
- Fault check, per lane: fault = addr[1:0]!=0 OR addr<DATA_START OR addr>=DATA_START+4*DATA_SIZE. Compare in 33 bits, with no overflow wrap.
- A faulting request never asserts its dmem write enable. Its response has fault=1 and rdata=0. It never triggers a conflict.
- Conflict: both valid, both non-faulting, addr[31:2] equal, and at least one is a store. Two loads to the same word are not a conflict.
- Port mapping: lane 1 uses port 1, lane 2 uses port 2. When a port is inactive, its we=0 and its address and data are driven to 0.
- Inputs: the pipeline holds all req*_i stable while req_ready_o=0.
- FSM states are IDLE and SPLIT.
- IDLE, no conflict:
  - req_ready_o=1.
  - Both lanes are driven combinationally this cycle.
  - At the edge, the response registers capture dmem_rd*_i (loads), tag, fault, and valid=req_valid.
  - Latency is 1 cycle.
- IDLE, conflict:
  - req_ready_o=0.
  - Only lane 1 is driven on port 1; dmem_we2_o=0.
  - At the edge, the lane 1 response goes into a holding buffer (not yet visible), and the FSM moves to SPLIT.
  - resp*_valid_o=0 for that cycle's edge.
- SPLIT:
  - Lane 2 is driven on port 2; port 1 is inactive; req_ready_o=1.
  - At the edge, both responses are presented together (lane 1 from the buffer, lane 2 from the port), and the FSM moves to IDLE.
  - Total latency is 2 cycles.
- Resulting ordering: store→load returns the new data; load→store returns the old data; store→store leaves the lane 2 value in memory.
- Response registers reload every edge. resp*_valid_o deasserts on any edge where no pair completes, including the IDLE-conflict edge.
- Only one lane valid: that lane is issued, the other port is inactive, and no conflict is possible.
- Neither lane valid: both ports are inactive; req_ready_o=1 in IDLE.
- Undriven read data: high-Z dmem_rd*_i is never propagated. rdata is gated to 0 for stores, faults and invalid lanes.
- Reset (asynchronous):
  - FSM returns to IDLE.
  - All resp*_valid/fault/rdata/tag outputs and the holding buffer clear to 0.
- Reset mid-SPLIT: the buffered lane 1 response is discarded. A lane 1 store already written remains in memory, since memory has no reset.
- Combinational outputs during reset: req_ready_o=1 and dmem outputs follow IDLE decode, but no state updates.

Test Plan:
- Two loads, lane 1 @0x10000000 and lane 2 @0x10000004, with memory holding 0xAAAA0001 and 0xBBBB0002 → req_ready_o=1; next cycle resp1_rdata=0xAAAA0001, resp2_rdata=0xBBBB0002, both valid, tags echoed.
- Lane 1 stores 0x12345678 @0x10000010, lane 2 loads @0x10000010 → cycle 0: ready=0 and only dmem_we_o=1; cycle 1: ready=1; after the second edge both responses are valid and resp2_rdata=0x12345678.
- Lane 1 stores 0x11 and lane 2 stores 0x22, both @0x10000020 → dmem_we_o and dmem_we2_o are never high in the same cycle; the word ends as 0x22; both responses are valid together 2 cycles later.
- Lane 1 loads @0x10000002 (misaligned), lane 2 stores @0x10000100 (out of range when DATA_SIZE=64) → both faults=1, both rdata=0, no dmem write, latency 1.
- Two loads to the same word @0x10000008 → no split; ready=1; both rdata are equal after 1 cycle.
- Conflicting pair with reset asserted during SPLIT → outputs clear immediately; FSM is IDLE; no resp*_valid; the lane 1 store value persists in memory.

Source files
------------

// File: rtl/ucsbece154_lsu_dual.sv
// ucsbece154_lsu_dual: dual-lane load/store unit driving a two-port data memory
// Same-word hazards with a store are split over two cycles so lane 1 always acts first.
module ucsbece154_lsu_dual #(
  parameter logic [31:0] DATA_START = 32'h10000000,
  parameter int          DATA_SIZE  = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req1_valid_i,
  input  logic        req2_valid_i,
  input  logic        req1_we_i,
  input  logic        req2_we_i,
  input  logic [31:0] req1_addr_i,
  input  logic [31:0] req2_addr_i,
  input  logic [31:0] req1_wdata_i,
  input  logic [31:0] req2_wdata_i,
  input  logic [4:0]  req1_tag_i,
  input  logic [4:0]  req2_tag_i,
  output logic        req_ready_o,
  output logic        resp1_valid_o,
  output logic        resp2_valid_o,
  output logic [31:0] resp1_rdata_o,
  output logic [31:0] resp2_rdata_o,
  output logic [4:0]  resp1_tag_o,
  output logic [4:0]  resp2_tag_o,
  output logic        resp1_fault_o,
  output logic        resp2_fault_o,
  output logic        dmem_we_o,
  output logic        dmem_we2_o,
  output logic [31:0] dmem_a_o,
  output logic [31:0] dmem_a2_o,
  output logic [31:0] dmem_wd_o,
  output logic [31:0] dmem_wd2_o,
  input  logic [31:0] dmem_rd_i,
  input  logic [31:0] dmem_rd2_i
);
  typedef enum logic {IDLE, SPLIT} state_t;
  localparam logic [32:0] LO = {1'b0, DATA_START};
  localparam logic [32:0] HI = LO + 33'(4 * DATA_SIZE);
  state_t state, state_n;
  logic f1, f2, ok1, ok2, conflict, split_start, act1, act2;
  logic [31:0] rd1, rd2, buf_rdata;
  logic [4:0] buf_tag;
  logic buf_valid;
  assign f1 = (req1_addr_i[1:0] != 2'b00) || ({1'b0, req1_addr_i} < LO) || ({1'b0, req1_addr_i} >= HI);
  assign f2 = (req2_addr_i[1:0] != 2'b00) || ({1'b0, req2_addr_i} < LO) || ({1'b0, req2_addr_i} >= HI);
  assign ok1 = req1_valid_i & ~f1;
  assign ok2 = req2_valid_i & ~f2;
  assign conflict = ok1 & ok2 & (req1_addr_i[31:2] == req2_addr_i[31:2]) & (req1_we_i | req2_we_i);
  assign split_start = (state == IDLE) & conflict;
  // read data is gated so a floating memory bus never reaches the response registers
  assign rd1 = (ok1 & ~req1_we_i) ? dmem_rd_i : 32'd0;
  assign rd2 = (ok2 & ~req2_we_i) ? dmem_rd2_i : 32'd0;
  always_comb begin
    state_n = split_start ? SPLIT : IDLE;
    act1 = (state == IDLE) & ok1;
    act2 = ok2 & ((state == SPLIT) | ~conflict);
    req_ready_o = reset | (state == SPLIT) | ~conflict;
    dmem_we_o = act1 & req1_we_i;
    dmem_a_o = act1 ? req1_addr_i : 32'd0;
    dmem_wd_o = act1 ? req1_wdata_i : 32'd0;
    dmem_we2_o = act2 & req2_we_i;
    dmem_a2_o = act2 ? req2_addr_i : 32'd0;
    dmem_wd2_o = act2 ? req2_wdata_i : 32'd0;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      resp1_valid_o <= 1'b0;
      resp1_rdata_o <= 32'd0;
      resp1_tag_o <= 5'd0;
      resp1_fault_o <= 1'b0;
      resp2_valid_o <= 1'b0;
      resp2_rdata_o <= 32'd0;
      resp2_tag_o <= 5'd0;
      resp2_fault_o <= 1'b0;
      buf_valid <= 1'b0;
      buf_rdata <= 32'd0;
      buf_tag <= 5'd0;
    end else begin
      state <= state_n;
      resp1_valid_o <= ~split_start & ((state == SPLIT) ? buf_valid : req1_valid_i);
      resp1_rdata_o <= split_start ? 32'd0 : (state == SPLIT) ? buf_rdata : rd1;
      resp1_tag_o <= split_start ? 5'd0 : (state == SPLIT) ? buf_tag : req1_tag_i;
      resp1_fault_o <= ~split_start & (state == IDLE) & req1_valid_i & f1;
      resp2_valid_o <= ~split_start & req2_valid_i;
      resp2_rdata_o <= split_start ? 32'd0 : rd2;
      resp2_tag_o <= split_start ? 5'd0 : req2_tag_i;
      resp2_fault_o <= ~split_start & req2_valid_i & f2;
      if (split_start) begin
        buf_valid <= 1'b1;
        buf_rdata <= rd1;
        buf_tag <= req1_tag_i;
      end
    end
  end
endmodule

// File: tb/tb_ucsbece154_lsu_dual.sv
// tb_ucsbece154_lsu_dual: randomized and directed checks of the dual-lane LSU
// against a program-order memory model and a queue of expected responses.
module tb_ucsbece154_lsu_dual;
  localparam logic [31:0] START = 32'h10000000;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;
  logic req1_valid_i, req2_valid_i, req1_we_i, req2_we_i;
  logic [31:0] req1_addr_i, req2_addr_i, req1_wdata_i, req2_wdata_i;
  logic [4:0] req1_tag_i, req2_tag_i;
  logic req_ready_o, resp1_valid_o, resp2_valid_o, resp1_fault_o, resp2_fault_o;
  logic [31:0] resp1_rdata_o, resp2_rdata_o;
  logic [4:0] resp1_tag_o, resp2_tag_o;
  logic dmem_we_o, dmem_we2_o;
  logic [31:0] dmem_a_o, dmem_a2_o, dmem_wd_o, dmem_wd2_o, dmem_rd_i, dmem_rd2_i;

  ucsbece154_lsu_dual dut (
    .clk(clk), .reset(reset),
    .req1_valid_i(req1_valid_i), .req2_valid_i(req2_valid_i),
    .req1_we_i(req1_we_i), .req2_we_i(req2_we_i),
    .req1_addr_i(req1_addr_i), .req2_addr_i(req2_addr_i),
    .req1_wdata_i(req1_wdata_i), .req2_wdata_i(req2_wdata_i),
    .req1_tag_i(req1_tag_i), .req2_tag_i(req2_tag_i),
    .req_ready_o(req_ready_o),
    .resp1_valid_o(resp1_valid_o), .resp2_valid_o(resp2_valid_o),
    .resp1_rdata_o(resp1_rdata_o), .resp2_rdata_o(resp2_rdata_o),
    .resp1_tag_o(resp1_tag_o), .resp2_tag_o(resp2_tag_o),
    .resp1_fault_o(resp1_fault_o), .resp2_fault_o(resp2_fault_o),
    .dmem_we_o(dmem_we_o), .dmem_we2_o(dmem_we2_o),
    .dmem_a_o(dmem_a_o), .dmem_a2_o(dmem_a2_o),
    .dmem_wd_o(dmem_wd_o), .dmem_wd2_o(dmem_wd2_o),
    .dmem_rd_i(dmem_rd_i), .dmem_rd2_i(dmem_rd2_i)
  );

  function automatic logic in_rng(input logic [31:0] a);
    return a >= START && a < START + 32'd256;
  endfunction
  function automatic logic [5:0] idx(input logic [31:0] a);
    logic [31:0] o;
    o = a - START;
    return o[7:2];
  endfunction
  function automatic logic flt(input logic [31:0] a);
    longint x;
    x = longint'(a);
    return a[1:0] != 2'b00 || x < 64'h10000000 || x >= 64'h10000000 + 4 * 64;
  endfunction

  // two-port memory environment, with a bench-side port used only for preloading
  logic [31:0] mem [64];
  logic pre_we;
  logic [5:0] pre_a;
  logic [31:0] pre_d;
  assign dmem_rd_i = in_rng(dmem_a_o) ? mem[idx(dmem_a_o)] : 'z;
  assign dmem_rd2_i = in_rng(dmem_a2_o) ? mem[idx(dmem_a2_o)] : 'z;
  always @(posedge clk) begin
    if (pre_we) mem[pre_a] <= pre_d;
    if (dmem_we_o && in_rng(dmem_a_o)) mem[idx(dmem_a_o)] <= dmem_wd_o;
    if (dmem_we2_o && in_rng(dmem_a2_o)) mem[idx(dmem_a2_o)] <= dmem_wd2_o;
  end

  typedef struct packed {
    logic v1, f1; logic [4:0] t1; logic [31:0] r1;
    logic v2, f2; logic [4:0] t2; logic [31:0] r2;
  } exp_t;
  exp_t q[$];
  logic [31:0] ref_mem [64];
  logic hold = 1'b0;
  int passed = 0, total = 0;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
  endtask

  // one entry per clock edge, checked after that edge
  always @(negedge clk) begin
    exp_t e;
    if (!hold && q.size() > 0) begin
      e = q.pop_front();
      chk("resp1_valid", 32'(resp1_valid_o), 32'(e.v1));
      chk("resp2_valid", 32'(resp2_valid_o), 32'(e.v2));
      if (e.v1) begin
        chk("resp1_fault", 32'(resp1_fault_o), 32'(e.f1));
        chk("resp1_rdata", resp1_rdata_o, e.r1);
        chk("resp1_tag", 32'(resp1_tag_o), 32'(e.t1));
      end
      if (e.v2) begin
        chk("resp2_fault", 32'(resp2_fault_o), 32'(e.f2));
        chk("resp2_rdata", resp2_rdata_o, e.r2);
        chk("resp2_tag", 32'(resp2_tag_o), 32'(e.t2));
      end
    end
  end

  task automatic drive(input logic v1, w1, input logic [31:0] a1, d1, input logic [4:0] t1,
                       input logic v2, w2, input logic [31:0] a2, d2, input logic [4:0] t2);
    exp_t e;
    logic ok1, ok2, cf;
    ok1 = v1 && !flt(a1);
    ok2 = v2 && !flt(a2);
    cf = ok1 && ok2 && (a1 >> 2) == (a2 >> 2) && (w1 || w2);
    e = '0;
    e.v1 = v1; e.t1 = t1; e.f1 = v1 && flt(a1);
    e.v2 = v2; e.t2 = t2; e.f2 = v2 && flt(a2);
    if (ok1) begin
      if (w1) ref_mem[idx(a1)] = d1;
      else e.r1 = ref_mem[idx(a1)];
    end
    if (ok2) begin
      if (w2) ref_mem[idx(a2)] = d2;
      else e.r2 = ref_mem[idx(a2)];
    end
    @(negedge clk);
    #1;
    pre_we = 1'b0;
    req1_valid_i = v1; req1_we_i = w1; req1_addr_i = a1; req1_wdata_i = d1; req1_tag_i = t1;
    req2_valid_i = v2; req2_we_i = w2; req2_addr_i = a2; req2_wdata_i = d2; req2_tag_i = t2;
    #1;
    chk("ready", 32'(req_ready_o), 32'(!cf));
    chk("we1", 32'(dmem_we_o), 32'(ok1 && w1));
    chk("a1", dmem_a_o, ok1 ? a1 : 32'd0);
    if (cf) begin
      chk("we2_first", 32'(dmem_we2_o), 32'd0);
      q.push_back('0);
      @(negedge clk);
      #2;
      chk("ready_second", 32'(req_ready_o), 32'd1);
      chk("we1_second", 32'(dmem_we_o), 32'd0);
      chk("we2_second", 32'(dmem_we2_o), 32'(w2));
      chk("a2_second", dmem_a2_o, a2);
    end else begin
      chk("we2", 32'(dmem_we2_o), 32'(ok2 && w2));
      chk("a2", dmem_a2_o, ok2 ? a2 : 32'd0);
    end
    q.push_back(e);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
  endtask

  task automatic preload(input logic [5:0] i, input logic [31:0] v);
    @(negedge clk);
    #1;
    req1_valid_i = 1'b0; req2_valid_i = 1'b0;
    pre_we = 1'b1; pre_a = i; pre_d = v;
    ref_mem[i] = v;
    q.push_back('0);
    @(posedge clk);
    #1;
    pre_we = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = int'($urandom_range(0, 15));
    if (r < 10) return START + 32'(4 * $urandom_range(0, 5));
    if (r < 12) return START + 32'(4 * $urandom_range(0, 63));
    if (r == 12) return START + 32'(4 * $urandom_range(0, 63)) + 32'($urandom_range(1, 3));
    if (r == 13) return START + 32'd256;
    if (r == 14) return START - 32'd4;
    return 32'hFFFFFFFC;
  endfunction

  initial begin
    reset = 1'b1; pre_we = 1'b0; pre_a = '0; pre_d = '0;
    req1_valid_i = 0; req2_valid_i = 0; req1_we_i = 0; req2_we_i = 0;
    req1_addr_i = 0; req2_addr_i = 0; req1_wdata_i = 0; req2_wdata_i = 0;
    req1_tag_i = 0; req2_tag_i = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_resp1_valid", 32'(resp1_valid_o), 32'd0);
    chk("reset_resp2_valid", 32'(resp2_valid_o), 32'd0);
    chk("reset_rdata", resp1_rdata_o | resp2_rdata_o, 32'd0);
    chk("reset_ready", 32'(req_ready_o), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 64; i++) preload(6'(i), $urandom);

    preload(0, 32'hAAAA0001);
    preload(1, 32'hBBBB0002);
    drive(1, 0, START, 0, 5'd3, 1, 0, START + 4, 0, 5'd4);
    idle();
    chk("t1_rdata1", resp1_rdata_o, 32'hAAAA0001);
    chk("t1_rdata2", resp2_rdata_o, 32'hBBBB0002);
    chk("t1_tags", {resp1_tag_o, resp2_tag_o}, {5'd3, 5'd4});

    drive(1, 1, START + 32'h10, 32'h12345678, 5'd5, 1, 0, START + 32'h10, 0, 5'd6);
    idle();
    chk("t2_rdata2", resp2_rdata_o, 32'h12345678);

    drive(1, 1, START + 32'h20, 32'h11, 5'd7, 1, 1, START + 32'h20, 32'h22, 5'd8);
    idle();
    chk("t3_mem", mem[8], 32'h22);

    drive(1, 0, START + 2, 0, 5'd9, 1, 1, START + 32'h100, 32'hDEAD, 5'd10);
    idle();
    chk("t4_faults", {resp1_fault_o, resp2_fault_o}, 32'd3);
    chk("t4_rdata", resp1_rdata_o | resp2_rdata_o, 32'd0);

    preload(2, 32'hCAFE0008);
    drive(1, 0, START + 8, 0, 5'd11, 1, 0, START + 8, 0, 5'd12);
    idle();
    chk("t5_same_load", {resp1_rdata_o, resp2_rdata_o}, {32'hCAFE0008, 32'hCAFE0008});

    repeat (400) begin
      drive($urandom_range(0, 3) != 0, 1'($urandom), rand_addr(), $urandom, 5'($urandom),
            $urandom_range(0, 3) != 0, 1'($urandom), rand_addr(), $urandom, 5'($urandom));
    end
    idle();
    idle();
    for (int i = 0; i < 64; i++) chk("mem_final", mem[i], ref_mem[i]);

    // reset while the split is in progress
    hold = 1'b1;
    q.delete();
    @(negedge clk);
    #1;
    req1_valid_i = 1; req1_we_i = 1; req1_addr_i = START + 32'h30; req1_wdata_i = 32'h5A5A5A5A; req1_tag_i = 5'd13;
    req2_valid_i = 1; req2_we_i = 0; req2_addr_i = START + 32'h30; req2_wdata_i = 0; req2_tag_i = 5'd14;
    @(posedge clk);
    #1;
    chk("rst_split_valid", 32'(resp1_valid_o | resp2_valid_o), 32'd0);
    chk("rst_split_ready", 32'(req_ready_o), 32'd1);
    chk("rst_split_a2", dmem_a2_o, START + 32'h30);
    reset = 1'b1;
    #1;
    chk("rst_ready", 32'(req_ready_o), 32'd1);
    chk("rst_idle_a2", dmem_a2_o, 32'd0);
    chk("rst_valid", 32'(resp1_valid_o | resp2_valid_o), 32'd0);
    chk("rst_mem", mem[12], 32'h5A5A5A5A);
    req1_valid_i = 0; req2_valid_i = 0;
    ref_mem[12] = 32'h5A5A5A5A;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    #2;
    chk("rst_buf_dropped", 32'(resp1_valid_o), 32'd0);
    hold = 1'b0;
    drive(0, 0, 0, 0, 5'd0, 1, 0, START + 32'h30, 0, 5'd15);
    idle();
    chk("rst_store_kept", resp2_rdata_o, 32'h5A5A5A5A);
    idle();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
